field_write_arbiter: RTL and testbench

- Shares one WIDTH-bit register `Q` among NREQ requesters; each requester writes a subset of bits selected by its own mask.
- Round-robin arbitration; the winning requester's masked data is written to `Q` and that requester gets a one-cycle `GNT` pulse.
- Per-bit `VALID` flags record which bits have been written since reset.
- Sits between independent field-update sources and a shared control/status register.

---
 rtl/field_write_arbiter.sv | 126 ++++++++++++
 tb/tb_field_write_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/field_write_arbiter.sv
// Round-robin arbiter sharing one masked-write register among NREQ requesters.
// Define FIELD_WRITE_MERGE_EN to also grant later requesters with disjoint masks.
module field_write_arbiter #(
    parameter int               WIDTH     = 4,
    parameter int               NREQ      = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] WMASK,
    input  logic [NREQ*WIDTH-1:0] WDATA,
    output logic [NREQ-1:0]       GNT,
    output logic [WIDTH-1:0]      Q,
    output logic [WIDTH-1:0]      VALID,
    output logic                  BUSY,
    output logic [2:0]            LAST_ID
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  valid_q, valid_d;
    logic [2:0]        last_id_q, last_id_d;
    logic [2:0]        ptr_q, ptr_d;

    logic [NREQ-1:0]   elig;
    logic [WIDTH-1:0]  used;
    logic              found;
    int                win;

    function automatic int wrap(input int v);
        return v % NREQ;
    endfunction

    // A requester granted last edge sits out this one.
    assign elig = REQ & ~gnt_q;

    always_comb begin
        found   = 1'b0;
        win     = 0;
        gnt_d   = '0;
        used    = '0;
        q_d     = q_q;
        valid_d = valid_q;

        for (int o = 0; o < NREQ; o++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && elig[i] && i == wrap(int'(ptr_q) + o)) begin
                    found = 1'b1;
                    win   = i;
                end
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            if (found && i == win) begin
                gnt_d[i] = 1'b1;
                used     = WMASK[i*WIDTH +: WIDTH];
            end
        end

`ifdef FIELD_WRITE_MERGE_EN
        // Later requesters join only if their mask misses every bit taken so far.
        for (int o = 1; o < NREQ; o++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (found && elig[i] && i == wrap(win + o) &&
                    (WMASK[i*WIDTH +: WIDTH] & used) == '0) begin
                    gnt_d[i] = 1'b1;
                    used     = used | WMASK[i*WIDTH +: WIDTH];
                end
            end
        end
`endif

        for (int i = 0; i < NREQ; i++) begin
            if (gnt_d[i]) begin
                q_d = (q_d & ~WMASK[i*WIDTH +: WIDTH]) |
                      (WDATA[i*WIDTH +: WIDTH] & WMASK[i*WIDTH +: WIDTH]);
                valid_d = valid_d | WMASK[i*WIDTH +: WIDTH];
            end
        end

        last_id_d = found ? 3'(win) : last_id_q;
        ptr_d     = found ? 3'(wrap(win + 1)) : ptr_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = GRANT;
            GRANT:   if (!found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            q_q       <= RESET_VAL;
            valid_q   <= '0;
            last_id_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            last_id_q <= last_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign GNT     = gnt_q;
    assign Q       = q_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q == GRANT);
    assign LAST_ID = last_id_q;

endmodule

// File: tb/tb_field_write_arbiter.sv
// Directed bench for field_write_arbiter (WIDTH=4, NREQ=3).
// Expectations are hand-derived; merge-build variants sit under FIELD_WRITE_MERGE_EN.
module tb_field_write_arbiter;

    logic        CLK;
    logic        RST_N;
    logic [2:0]  REQ;
    logic [11:0] WMASK;
    logic [11:0] WDATA;
    logic [2:0]  GNT;
    logic [3:0]  Q;
    logic [3:0]  VALID;
    logic        BUSY;
    logic [2:0]  LAST_ID;

    int checks = 0;
    int errors = 0;

    field_write_arbiter #(
        .WIDTH(4),
        .NREQ(3),
        .RESET_VAL(4'b0000)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .REQ(REQ),
        .WMASK(WMASK),
        .WDATA(WDATA),
        .GNT(GNT),
        .Q(Q),
        .VALID(VALID),
        .BUSY(BUSY),
        .LAST_ID(LAST_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        REQ   = 3'b000;
        WMASK = '0;
        WDATA = '0;
        tick();
        tick();
        RST_N = 1'b1;

        // idle edge after reset
        tick();
        chk("rst_q", 32'(Q), 32'b0000);
        chk("rst_valid", 32'(VALID), 32'b0000);
        chk("rst_gnt", 32'(GNT), 32'b000);
        chk("rst_busy", 32'(BUSY), 32'b0);
        chk("rst_last", 32'(LAST_ID), 32'd0);

        // single requester, back-to-back exclusion
        REQ   = 3'b001;
        WMASK = 12'b0000_0000_0010;
        WDATA = 12'b0000_0000_0000;
        tick();
        chk("s2_gnt", 32'(GNT), 32'b001);
        chk("s2_q", 32'(Q), 32'b0000);
        chk("s2_valid", 32'(VALID), 32'b0010);
        chk("s2_last", 32'(LAST_ID), 32'd0);
        chk("s2_busy", 32'(BUSY), 32'b1);
        tick();
        chk("s2_gap_gnt", 32'(GNT), 32'b000);
        chk("s2_gap_busy", 32'(BUSY), 32'b0);
        tick();
        chk("s2_regnt", 32'(GNT), 32'b001);

        // asynchronous reset in mid-cycle while granted
        REQ = 3'b000;
        tick();
        REQ = 3'b001;
        tick();
        chk("ar_pre_gnt", 32'(GNT), 32'b001);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_gnt", 32'(GNT), 32'b000);
        chk("ar_busy", 32'(BUSY), 32'b0);
        chk("ar_valid", 32'(VALID), 32'b0000);
        chk("ar_q", 32'(Q), 32'b0000);
        REQ   = 3'b000;
        RST_N = 1'b1;
        tick();
        chk("ar_idle_gnt", 32'(GNT), 32'b000);

        // three requesters, disjoint masks, PTR=0
        REQ   = 3'b111;
        WMASK = 12'b1000_0100_0010;
        WDATA = 12'b1111_1111_1111;
        tick();
`ifdef FIELD_WRITE_MERGE_EN
        chk("s3m_gnt", 32'(GNT), 32'b111);
        chk("s3m_q", 32'(Q), 32'b1110);
        chk("s3m_last", 32'(LAST_ID), 32'd0);
        REQ = 3'b000;
        tick();
        // PTR should be 1: requester 1 beats 0
        REQ   = 3'b011;
        WMASK = 12'b0000_0001_0001;
        WDATA = 12'b0000_0000_0000;
        tick();
        chk("s3m_ptr", 32'(GNT), 32'b010);
        REQ   = 3'b000;
        WMASK = 12'b1000_0100_0010;
        WDATA = 12'b1111_1111_1111;
        tick();
`else
        chk("s3_gnt0", 32'(GNT), 32'b001);
        chk("s3_q0", 32'(Q), 32'b0010);
        tick();
        chk("s3_gnt1", 32'(GNT), 32'b010);
        chk("s3_q1", 32'(Q), 32'b0110);
        tick();
        chk("s3_gnt2", 32'(GNT), 32'b100);
        chk("s3_q2", 32'(Q), 32'b1110);
        chk("s3_valid", 32'(VALID), 32'b1110);
        chk("s3_last", 32'(LAST_ID), 32'd2);
        REQ = 3'b000;
        tick();
        chk("s3_idle_busy", 32'(BUSY), 32'b0);
`endif

        // wrap-around from PTR=2
        REQ = 3'b010;
        tick();
        chk("s4_setup", 32'(GNT), 32'b010);
        REQ = 3'b000;
        tick();
        REQ   = 3'b011;
        WMASK = 12'b0000_0001_0001;
        WDATA = 12'b0000_0000_0000;
        tick();
        chk("s4_gnt0", 32'(GNT), 32'b001);
        chk("s4_last0", 32'(LAST_ID), 32'd0);
        tick();
        chk("s4_gnt1", 32'(GNT), 32'b010);
        chk("s4_q", 32'(Q), 32'b1110);
        chk("s4_valid", 32'(VALID), 32'b1111);
        REQ = 3'b000;
        tick();

        // zero mask still consumes a turn; leaves PTR=1
        REQ   = 3'b001;
        WMASK = 12'b0000_0000_0000;
        WDATA = 12'b1111_1111_1111;
        tick();
        chk("zm_gnt", 32'(GNT), 32'b001);
        chk("zm_q", 32'(Q), 32'b1110);
        REQ = 3'b000;
        tick();

        // overlapping masks from PTR=1
        REQ   = 3'b011;
        WMASK = 12'b0000_0011_0011;
        WDATA = 12'b0000_0010_0001;
        tick();
        chk("s5_gnt1", 32'(GNT), 32'b010);
        chk("s5_q1", 32'(Q), 32'b1110);
        tick();
        chk("s5_gnt0", 32'(GNT), 32'b001);
        chk("s5_q0", 32'(Q), 32'b1101);
        chk("s5_last", 32'(LAST_ID), 32'd0);
        REQ = 3'b000;
        tick();
        chk("s5_idle", 32'(GNT), 32'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
